counter_up_mod: RTL and testbench

//   Programmable modulo up-counter; the counting-up counterpart of the team's
//   4-bit down counter.
//   - Counts 0..MAX while enabled. Supports synchronous clear and parallel load.
//   - Selectable wrap or saturate at MAX.
//   - Provides a terminal-count output for cascading, a one-cycle wrap pulse,
//     and a sticky overflow flag.
//   - Used as a timebase/prescaler and as the up-direction counter in

---
 rtl/counter_up_mod.sv | 70 +++++++
 tb/tb_counter_up_mod.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/counter_up_mod.sv
// Programmable modulo up-counter with clear/load, wrap-or-saturate at MAX,
// combinational terminal count, registered wrap pulse and sticky overflow.
module counter_up_mod #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 15,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_max;

  assign at_max = (count_q == MAX_V);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      // Out-of-range load values clamp so count never leaves 0..MAX.
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (!at_max) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        ovf_d = 1'b1;
        if (SATURATE == 0) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  // Combinational so a cascaded stage with en=tc steps on this stage's wrap edge.
  assign tc    = at_max & en & ~clr & ~load;

endmodule

// File: tb/tb_counter_up_mod.sv
// Bench: five counter_up_mod variants driven in parallel, checked each cycle
// against a behavioural model plus directed literal expectations.
module tb_counter_up_mod;
  localparam int NI = 5;
  // variants: 0 default, 1 MAX=9, 2 saturate, 3 MAX=0 wrap, 4 MAX=0 saturate

  logic clk, rst, en, clr, load;
  logic [3:0] load_val;
  logic [3:0] cnt [NI];
  logic [NI-1:0] tcv, wrv, ovv;

  int n_chk = 0;
  int n_fail = 0;

  function automatic int mmax(int i);
    case (i)
      0: return 15;
      1: return 9;
      2: return 15;
      default: return 0;
    endcase
  endfunction

  function automatic bit msat(int i);
    return (i == 2) || (i == 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    counter_up_mod #(
      .WIDTH(4),
      .MAX((g == 0 || g == 2) ? 15 : (g == 1) ? 9 : 0),
      .SATURATE((g == 2 || g == 4) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .count(cnt[g]), .tc(tcv[g]), .wrap(wrv[g]), .ovf(ovv[g])
    );
  end

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Behavioural model: spec rules in plain integer arithmetic.
  int m_cnt [NI];
  bit m_wr [NI];
  bit m_ov [NI];

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        m_cnt[i] = 0; m_wr[i] = 0; m_ov[i] = 0;
      end else if (clr) begin
        m_cnt[i] = 0; m_wr[i] = 0; m_ov[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > mmax(i)) ? mmax(i) : int'(load_val);
        m_wr[i] = 0;
      end else if (en) begin
        if (m_cnt[i] < mmax(i)) begin
          m_cnt[i] = m_cnt[i] + 1; m_wr[i] = 0;
        end else if (msat(i)) begin
          m_wr[i] = 0; m_ov[i] = 1;
        end else begin
          m_cnt[i] = 0; m_wr[i] = 1; m_ov[i] = 1;
        end
      end else begin
        m_wr[i] = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit m_tc;
      m_tc = (m_cnt[i] == mmax(i)) && en && !clr && !load;
      n_chk++;
      if (cnt[i] !== 4'(m_cnt[i]) || tcv[i] !== m_tc || wrv[i] !== m_wr[i] || ovv[i] !== m_ov[i]) begin
        n_fail++;
        $display("FAIL model[%0d]: count=%0d tc=%b wrap=%b ovf=%b expected count=%0d tc=%b wrap=%b ovf=%b at %0t",
                 i, cnt[i], tcv[i], wrv[i], ovv[i], m_cnt[i], m_tc, m_wr[i], m_ov[i], $time);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; en = 0; clr = 0; load = 0; load_val = '0;
    #1 rst = 1'b0;
    #1 chk("reset_count", cnt[0], 0);
    tick(2);
    rst = 1'b1;
    tick();
    chk("post_reset_count", cnt[0], 0);

    // 1: async reset with a preloaded count
    load = 1; load_val = 4'd9;
    tick();
    load = 0;
    chk("load9_d0", cnt[0], 9);
    chk("load9_clamp_max0", cnt[3], 0);
    #5 rst = 1'b0;
    #1;
    chk("async_rst_count", cnt[0], 0);
    chk("async_rst_wrap", wrv[0], 0);
    chk("async_rst_ovf", ovv[0], 0);
    #2 rst = 1'b1;

    // 2: free-running wrap with defaults
    en = 1;
    tick(15);
    chk("d0_at15", cnt[0], 15);
    chk("d0_tc_at15", tcv[0], 1);
    tick();
    chk("d0_wrapped", cnt[0], 0);
    chk("d0_wrap_pulse", wrv[0], 1);
    chk("d0_ovf_set", ovv[0], 1);
    chk("max0_wrap", wrv[3], 1);
    chk("max0_tc", tcv[3], 1);
    chk("max0_sat_wrap", wrv[4], 0);
    tick();
    chk("d0_after_wrap", cnt[0], 1);
    chk("d0_wrap_one_cycle", wrv[0], 0);
    chk("d0_ovf_sticky", ovv[0], 1);
    chk("d1_mod10", cnt[1], 7);
    en = 0;

    // 3: modulo 10 with clamped load
    clr = 1; tick(); clr = 0;
    load = 1; load_val = 4'd12; tick(); load = 0;
    chk("d1_load_clamp", cnt[1], 9);
    chk("d0_load12", cnt[0], 12);
    en = 1; tick(); en = 0;
    chk("d1_wrap_count", cnt[1], 0);
    chk("d1_wrap_pulse", wrv[1], 1);

    // 4: saturate
    clr = 1; tick(); clr = 0;
    en = 1;
    tick(15);
    chk("d2_reach15", cnt[2], 15);
    chk("d2_ovf_not_yet", ovv[2], 0);
    tick(5);
    chk("d2_hold15", cnt[2], 15);
    chk("d2_ovf", ovv[2], 1);
    chk("d2_no_wrap", wrv[2], 0);
    chk("d0_20mod16", cnt[0], 4);
    en = 0;

    // 5: priority
    clr = 1; tick(); clr = 0;
    en = 1; tick(7);
    chk("d0_at7", cnt[0], 7);
    chk("max0_ovf_before_clr", ovv[3], 1);
    clr = 1; load = 1; load_val = 4'd5; tick();
    chk("prio_clr_count", cnt[0], 0);
    chk("prio_clr_ovf", ovv[3], 0);
    clr = 0; load_val = 4'd3; tick();
    chk("prio_load_over_en", cnt[0], 3);
    load = 0; en = 0; tick(5);
    chk("hold5", cnt[0], 3);

    // 6: reset pulse mid-count
    load = 1; load_val = 4'd12; tick(); load = 0;
    chk("d0_at12", cnt[0], 12);
    en = 1;
    #5 rst = 1'b0;
    #1 chk("mid_rst_count", cnt[0], 0);
    #2 rst = 1'b1;
    tick();
    chk("after_rst_1", cnt[0], 1);
    tick();
    chk("after_rst_2", cnt[0], 2);
    en = 0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
